// File: rtl/nios_key_in_if.sv
// Avalon-MM slave bus of the key input port: word address, select,
// active-low write strobe, write data and zero-latency read data.
interface nios_key_in_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/nios_key_in.sv
// Debounced active-low key input port with press-edge capture, an interrupt
// mask and a level irq, read and written over a small Avalon-MM register map.
module nios_key_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   nios_key_in_if.slave     bus,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] deb_q, deb_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] press;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      unused_wdata;
   logic             wr;

   assign unused_wdata = bus.writedata;
   assign wdata        = bus.writedata[WIDTH-1:0];
   assign wr           = bus.chipselect & ~bus.write_n;

   // A new level is accepted only after the counter runs out with sync2
   // continuously differing from the debounced value.
   always_comb begin
      deb_d = deb_q;
      press = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
            press[i] = ~sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      mask_d = mask_q;
      clr    = '0;
      if (wr && bus.address == ADDR_IRQMASK) mask_d = wdata;
      if (wr && bus.address == ADDR_EDGECAP) clr = wdata;
      // A press landing on the same edge as its clear survives.
      edgecap_d = (edgecap_q & ~clr) | press;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         deb_q     <= '1;
         mask_q    <= '0;
         edgecap_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q   <= in_port;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         mask_q    <= mask_d;
         edgecap_q <= edgecap_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_DATA:    bus.readdata[WIDTH-1:0] = deb_q;
         ADDR_IRQMASK: bus.readdata[WIDTH-1:0] = mask_q;
         ADDR_EDGECAP: bus.readdata[WIDTH-1:0] = edgecap_q;
         default:      bus.readdata = '0;
      endcase
   end

   assign irq = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_nios_key_in.sv
// Directed bench for nios_key_in with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_nios_key_in;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;
  int               n_checks;
  int               n_errors;

  nios_key_in_if bus ();

  nios_key_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .in_port (in_port),
    .irq     (irq)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    tick(1);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
  endtask

  task automatic bus_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    bus.address = addr;
    #1;
    check_val(tag, bus.readdata, exp);
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    reset_n        = 1'b0;
    in_port        = 4'hF;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // reset state, while held and after release
    tick(2);
    bus_read("rst_data", 2'd0, 32'hF);
    bus_read("rst_edgecap", 2'd3, 32'h0);
    check_val("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick(1);
    bus_read("data_after_rst", 2'd0, 32'hF);
    bus_read("rsvd_after_rst", 2'd1, 32'h0);
    bus_read("mask_after_rst", 2'd2, 32'h0);
    bus_read("edge_after_rst", 2'd3, 32'h0);
    check_val("irq_after_rst", {31'b0, irq}, 32'h0);

    // reserved address ignores writes
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read("rsvd_write_ign", 2'd1, 32'h0);

    // bit0 press: visible after edge k+5, not after k+4
    in_port = 4'hE;
    tick(5);
    bus_read("press0_data_early", 2'd0, 32'hF);
    bus_read("press0_edge_early", 2'd3, 32'h0);
    tick(1);
    bus_read("press0_data", 2'd0, 32'hE);
    bus_read("press0_edge", 2'd3, 32'h1);
    check_val("press0_irq_masked", {31'b0, irq}, 32'h0);

    // clear, then release: release must not capture
    bus_write(2'd3, 32'h1);
    bus_read("clr0_edge", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(6);
    bus_read("rel0_data", 2'd0, 32'hF);
    bus_read("rel0_edge", 2'd3, 32'h0);

    // mask enabled: irq follows capture and clear
    bus_write(2'd2, 32'hFFFF_FFF1);
    bus_read("mask_rd", 2'd2, 32'h1);
    in_port = 4'hE;
    tick(5);
    check_val("irq_before_cap", {31'b0, irq}, 32'h0);
    tick(1);
    check_val("irq_after_cap", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h1);
    bus_read("irq_clr_edge", 2'd3, 32'h0);
    check_val("irq_after_clr", {31'b0, irq}, 32'h0);
    in_port = 4'hF;
    tick(6);

    // bit1 glitch of 3 clocks is rejected
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(2);
    bus_read("glitch_data_mid", 2'd0, 32'hF);
    tick(6);
    bus_read("glitch_data", 2'd0, 32'hF);
    bus_read("glitch_edge", 2'd3, 32'h0);

    // bit2 capture coincides with write-1-to-clear: set wins
    in_port = 4'hB;
    tick(5);
    bus_write(2'd3, 32'h4);
    bus_read("setwins_data", 2'd0, 32'hB);
    bus_read("setwins_edge", 2'd3, 32'h4);
    check_val("setwins_irq_masked", {31'b0, irq}, 32'h0);
    bus_write(2'd3, 32'h4);
    bus_read("clr2_edge", 2'd3, 32'h0);
    in_port = 4'hF;
    tick(6);

    // simultaneous presses on bits 0 and 1
    in_port = 4'hC;
    tick(6);
    bus_read("multi_data", 2'd0, 32'hC);
    bus_read("multi_edge", 2'd3, 32'h3);
    check_val("multi_irq", {31'b0, irq}, 32'h1);
    bus_write(2'd3, 32'h2);
    bus_read("partial_clr", 2'd3, 32'h1);
    bus_write(2'd3, 32'hF);
    in_port = 4'hF;
    tick(6);

    // reset mid-press on bit3, pin still low through release
    in_port = 4'h7;
    tick(2);
    reset_n = 1'b0;
    #1;
    bus_read("midrst_edge", 2'd3, 32'h0);
    bus_read("midrst_data", 2'd0, 32'hF);
    bus_read("midrst_mask", 2'd2, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    bus_read("postrst_edge_early", 2'd3, 32'h0);
    tick(1);
    bus_read("postrst_edge", 2'd3, 32'h8);
    bus_read("postrst_data", 2'd0, 32'h7);
    check_val("postrst_irq", {31'b0, irq}, 32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nios_key_in.md
NIOS_KEY_IN -- requirements
Module: nios_key_in

Interface
REQ-001 Parameter WIDTH, default 4: number of input pins.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable clocks required to accept a new pin level; legal range is 2..2^20.
REQ-003 Port clk, input, 1: the single clock; all state is rising-edge clocked.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port address, input, 2: Avalon-MM slave word address.
REQ-006 Port chipselect, input, 1: slave select.
REQ-007 Port write_n, input, 1: active-low write strobe.
REQ-008 Port writedata, input, 32: write data.
REQ-009 Port in_port, input, WIDTH: asynchronous key pins; active-low, 1 means released.
REQ-010 Port readdata, output, 32: read data; zero wait states, zero read latency.
REQ-011 Port irq, output, 1: level interrupt, active-high.

Function
REQ-012 Register map: 0 = DATA (RO); 1 = reserved (reads 0, writes ignored); 2 = IRQMASK (RW); 3 = EDGECAP (read, write-1-to-clear).
REQ-013 readdata is a combinational mux of the addressed register, zero-extended from WIDTH bits to 32; bits 31:WIDTH always read 0.
REQ-014 readdata does not depend on chipselect; reads have no side effects.
REQ-015 A write occurs on an edge where chipselect=1 and write_n=0; only writedata[WIDTH-1:0] is used.
REQ-016 Each in_port bit passes through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-017 Per bit i, a counter cnt[i] of width clog2(DEBOUNCE_CYCLES) works as follows:
- if sync2[i] == deb[i]: cnt[i] <= 0;
- else if cnt[i] == DEBOUNCE_CYCLES-1: deb[i] <= sync2[i] and cnt[i] <= 0;
- else cnt[i] <= cnt[i]+1.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES clocks at sync2 resets cnt[i] and leaves deb[i] unchanged.
REQ-019 Latency: an in_port step captured in sync1 at edge k appears in DATA after edge k+DEBOUNCE_CYCLES+1.
REQ-020 DATA reads deb[WIDTH-1:0].
REQ-021 EDGECAP[i] is set on the same edge on which deb[i] changes from 1 to 0 (key press). A 0-to-1 change (release) never sets it.
REQ-022 A write to address 3 clears each EDGECAP bit whose writedata bit is 1; bits written 0 are unchanged.
REQ-023 If an edge set and a write-1-to-clear hit the same bit on the same edge, the set wins and the bit reads 1.
REQ-024 A write to address 2 loads IRQMASK with writedata[WIDTH-1:0].
REQ-025 irq = OR over i of (EDGECAP[i] AND IRQMASK[i]). It is combinational from registered state, so it asserts after the setting edge and deasserts after the clearing edge.
REQ-026 Bits are fully independent; simultaneous presses on several bits each set their own EDGECAP bit.

Reset
REQ-027 While reset_n=0, asynchronously: sync1, sync2 and deb go to all ones (released); cnt, IRQMASK and EDGECAP go to 0; irq=0; readdata at address 0 reads 2^WIDTH-1.
REQ-028 Reset asserted mid-debounce discards the partial count; no edge is captured for a press that was in progress.
REQ-029 A pin held low through reset release is debounced afresh and sets EDGECAP DEBOUNCE_CYCLES+1 clocks after its first sync1 capture.

Verification (bench uses WIDTH=4, DEBOUNCE_CYCLES=4)
REQ-030 Reset, then read addresses 0..3 -> 0x0000000F, 0x0, 0x0, 0x0; irq=0.
REQ-031 in_port 0xF->0xE held, sampled at edge k -> DATA reads 0xE and EDGECAP reads 0x1 after edge k+5, not before; irq stays 0 while IRQMASK=0.
REQ-032 Write IRQMASK=0x1, then press bit0 -> irq=1 after the capture edge; write 0x1 to address 3 -> EDGECAP=0 and irq=0 after the next edge.
REQ-033 Bit1 low for 3 clocks, then high -> DATA stays 0xF and EDGECAP stays 0x0.
REQ-034 Bit2 capture edge coincides with a write of 0x4 to address 3 -> EDGECAP reads 0x4.
REQ-035 Assert reset_n=0 two clocks into a bit3 press, release it with the pin still low -> EDGECAP=0 during reset; EDGECAP=0x8 five clocks after the first post-reset sync1 capture.
